// File: rtl/display_framebuffer_pkg.sv
// Shared constants, write-op encodings and FSM state type for the 128x64 monochrome framebuffer.
package display_framebuffer_pkg;

  localparam int FB_COLUMNS = 128;
  localparam int FB_PAGES   = 8;
  localparam int FB_ADDR_W  = 10;

  localparam logic [1:0] WR_OP_CLR  = 2'd0;
  localparam logic [1:0] WR_OP_SET  = 2'd1;
  localparam logic [1:0] WR_OP_TGL  = 2'd2;
  localparam logic [1:0] WR_OP_BYTE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    RMW_READ,
    RMW_MOD,
    WR_BYTE,
    CLEAR
  } fb_state_e;

  // Applies a single-pixel operation to the byte holding 8 vertical pixels.
  function automatic logic [7:0] fb_pixel_op(input logic [1:0] op,
                                             input logic [7:0] cur,
                                             input logic [2:0] bit_idx);
    logic [7:0] mask;
    mask = 8'd1 << bit_idx;
    case (op)
      WR_OP_CLR: return cur & ~mask;
      WR_OP_SET: return cur | mask;
      WR_OP_TGL: return cur ^ mask;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/display_framebuffer_ram.sv
// Single-port framebuffer RAM: synchronous read-first, write enable, no reset so it maps to block RAM.
module fb_ram_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/display_framebuffer.sv
// Framebuffer owner: arbitrates one single-port RAM between refresh reads (highest priority),
// pixel/byte drawing writes and a full-screen clear sequencer.
module display_framebuffer
  import display_framebuffer_pkg::*;
#(
  parameter int COLUMNS = FB_COLUMNS,
  parameter int PAGES   = FB_PAGES,
  parameter int ADDR_W  = FB_ADDR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_read,
  input  logic [2:0] d_page_idx,
  input  logic [6:0] d_column_idx,
  output logic [7:0] d_data,
  output logic       d_data_ready,
  input  logic       wr_req,
  input  logic [1:0] wr_op,
  input  logic [6:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [2:0] wr_page,
  input  logic [7:0] wr_byte,
  output logic       wr_ready,
  input  logic       clr_req,
  input  logic [7:0] clr_value,
  output logic       clr_busy
);

  localparam int CELLS = COLUMNS * PAGES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [2:0] page, input logic [6:0] col);
    return ADDR_W'(page) * ADDR_W'(COLUMNS) + ADDR_W'(col);
  endfunction

  fb_state_e         state, state_nx;
  logic              rd_pend, rd_pend_nx;
  logic              wr_lat, wr_lat_nx;
  logic              clr_busy_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
  logic              ready_nx;
  logic              wr_accept, clr_accept;

  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        op_q;
  logic [6:0]        x_q;
  logic [5:0]        y_q;
  logic [2:0]        page_q;
  logic [7:0]        byte_q;
  logic [7:0]        clr_val_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  assign wr_accept  = wr_req && wr_ready;
  // A write accepted on the same edge wins over a clear request.
  assign clr_accept = clr_req && !clr_busy && !wr_lat && !wr_accept;

  fb_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(8)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nx  = state;
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = clr_val_q;
    case (state)
      IDLE: begin
        if (rd_pend)                      state_nx = RD_ISSUE;
        else if (clr_busy || clr_accept)  state_nx = CLEAR;
        else if (wr_lat)                  state_nx = (op_q == WR_OP_BYTE) ? WR_BYTE : RMW_READ;
      end
      RD_ISSUE: begin
        ram_addr = rd_addr;
        state_nx = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        state_nx = (clr_busy || clr_accept) ? CLEAR : IDLE;
      end
      RMW_READ: begin
        ram_addr = cell_addr(y_q[5:3], x_q);
        state_nx = RMW_MOD;
      end
      RMW_MOD: begin
        ram_addr  = cell_addr(y_q[5:3], x_q);
        ram_we    = 1'b1;
        ram_wdata = fb_pixel_op(op_q, ram_rdata, y_q[2:0]);
        state_nx  = IDLE;
      end
      WR_BYTE: begin
        ram_addr  = cell_addr(page_q, x_q);
        ram_we    = 1'b1;
        ram_wdata = byte_q;
        state_nx  = IDLE;
      end
      CLEAR: begin
        ram_addr  = clr_cnt;
        ram_we    = 1'b1;
        ram_wdata = clr_val_q;
        if (rd_pend)                     state_nx = RD_ISSUE;
        else if (clr_cnt == LAST_ADDR)   state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_pend_nx = rd_pend;
    if (d_read)                 rd_pend_nx = 1'b1;
    else if (state == RD_ISSUE) rd_pend_nx = 1'b0;

    wr_lat_nx = wr_lat;
    if (wr_accept)                                  wr_lat_nx = 1'b1;
    else if (state == RMW_MOD || state == WR_BYTE)  wr_lat_nx = 1'b0;

    clr_busy_nx = clr_busy;
    clr_cnt_nx  = clr_cnt;
    if (clr_accept) begin
      clr_busy_nx = 1'b1;
      clr_cnt_nx  = '0;
    end else if (state == CLEAR) begin
      if (clr_cnt == LAST_ADDR) begin
        clr_busy_nx = 1'b0;
        clr_cnt_nx  = '0;
      end else begin
        clr_cnt_nx = clr_cnt + 1'b1;
      end
    end

    // Registered so the write port opens on the edge that lands in a quiet IDLE.
    ready_nx = (state_nx == IDLE) && !rd_pend_nx && !wr_lat_nx && !clr_busy_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_pend      <= 1'b0;
      wr_lat       <= 1'b0;
      clr_busy     <= 1'b0;
      clr_cnt      <= '0;
      wr_ready     <= 1'b0;
      d_data       <= 8'h00;
      d_data_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_pend  <= rd_pend_nx;
      wr_lat   <= wr_lat_nx;
      clr_busy <= clr_busy_nx;
      clr_cnt  <= clr_cnt_nx;
      wr_ready <= ready_nx;
      if (state == RD_CAPTURE) d_data <= ram_rdata;
      // A newer request sampled after the issue keeps ready low until its own capture.
      if (d_read)                                d_data_ready <= 1'b0;
      else if (state == RD_CAPTURE && !rd_pend)  d_data_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (d_read) rd_addr <= cell_addr(d_page_idx, d_column_idx);
    if (wr_accept) begin
      op_q   <= wr_op;
      x_q    <= wr_x;
      y_q    <= wr_y;
      page_q <= wr_page;
      byte_q <= wr_byte;
    end
    if (clr_accept) clr_val_q <= clr_value;
  end

endmodule

// File: tb/tb_display_framebuffer.sv
// Directed plus randomized bench for display_framebuffer against a byte-array model of the screen.
module tb_display_framebuffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_read;
  logic [2:0] d_page_idx;
  logic [6:0] d_column_idx;
  logic [7:0] d_data;
  logic       d_data_ready;
  logic       wr_req;
  logic [1:0] wr_op;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [2:0] wr_page;
  logic [7:0] wr_byte;
  logic       wr_ready;
  logic       clr_req;
  logic [7:0] clr_value;
  logic       clr_busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [0:1023];

  display_framebuffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_read       (d_read),
    .d_page_idx   (d_page_idx),
    .d_column_idx (d_column_idx),
    .d_data       (d_data),
    .d_data_ready (d_data_ready),
    .wr_req       (wr_req),
    .wr_op        (wr_op),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_page      (wr_page),
    .wr_byte      (wr_byte),
    .wr_ready     (wr_ready),
    .clr_req      (clr_req),
    .clr_value    (clr_value),
    .clr_busy     (clr_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_apply(input int op, input int x, input int y, input int page,
                                      input logic [7:0] b);
    int idx;
    logic [7:0] m;
    if (op == 3) begin
      model[page * 128 + x] = b;
    end else begin
      idx = (y / 8) * 128 + x;
      m   = 8'(1 << (y % 8));
      if (op == 0)      model[idx] = model[idx] & ~m;
      else if (op == 1) model[idx] = model[idx] | m;
      else              model[idx] = model[idx] ^ m;
    end
  endfunction

  function automatic void model_fill(input int upto, input logic [7:0] v);
    for (int i = 0; i < upto; i++) model[i] = v;
  endfunction

  task automatic do_read(input int page, input int col, output logic [7:0] data, output int lat);
    d_read       = 1'b1;
    d_page_idx   = 3'(page);
    d_column_idx = 7'(col);
    tick();
    d_read = 1'b0;
    lat    = 0;
    while (d_data_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    data = d_data;
  endtask

  task automatic wait_wr_ready();
    int n;
    n = 0;
    while (wr_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("wr_ready_wait", 32'(wr_ready), 1);
  endtask

  task automatic do_write(input int op, input int x, input int y, input int page, input logic [7:0] b);
    wait_wr_ready();
    wr_req  = 1'b1;
    wr_op   = 2'(op);
    wr_x    = 7'(x);
    wr_y    = 6'(y);
    wr_page = 3'(page);
    wr_byte = b;
    tick();
    wr_req = 1'b0;
    model_apply(op, x, y, page, b);
    wait_wr_ready();
  endtask

  task automatic start_clear(input logic [7:0] v);
    clr_req   = 1'b1;
    clr_value = v;
    tick();
    clr_req = 1'b0;
  endtask

  initial begin
    logic [7:0] d, old;
    int lat, n, maxlat, pg, cl, x, y, op, a;

    rst_n = 1'b0; d_read = 1'b0; d_page_idx = '0; d_column_idx = '0;
    wr_req = 1'b0; wr_op = '0; wr_x = '0; wr_y = '0; wr_page = '0; wr_byte = '0;
    clr_req = 1'b0; clr_value = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_d_data", 32'(d_data), 0);
    chk("rst_d_data_ready", 32'(d_data_ready), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_clr_busy", 32'(clr_busy), 0);
    rst_n = 1'b1;
    tick();
    chk("wr_ready_after_rst", 32'(wr_ready), 1);

    // Full clear to 0x00 with no readers: busy for exactly 1024 cycles
    start_clear(8'h00);
    chk("clr_busy_rise", 32'(clr_busy), 1);
    chk("wr_ready_in_clear", 32'(wr_ready), 0);
    n = 0;
    while (clr_busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("clr_busy_cycles", n, 1024);
    model_fill(1024, 8'h00);

    // First read by hand: ready drops on the sampling edge, returns 3 edges later
    d_read = 1'b1; d_page_idx = 3'd0; d_column_idx = 7'd0;
    tick();
    d_read = 1'b0;
    chk("ready_low_after_req", 32'(d_data_ready), 0);
    lat = 0;
    while (d_data_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("read_best_latency", lat, 3);
    chk("read_zero_0", 32'(d_data), 0);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 1023);
      do_read(a / 128, a % 128, d, lat);
      chk("read_after_clear0", 32'(d), 0);
    end

    // Directed pixel and byte writes
    do_write(1, 5, 10, 0, 8'h00);
    do_read(1, 5, d, lat);
    chk("set_pixel_5_10", 32'(d), 32'h04);
    do_write(2, 5, 10, 0, 8'h00);
    do_read(1, 5, d, lat);
    chk("toggle_pixel_5_10", 32'(d), 32'h00);
    do_write(3, 127, 0, 7, 8'hA5);
    do_read(7, 127, d, lat);
    chk("byte_write_7_127", 32'(d), 32'hA5);

    // Read arriving the cycle after a set-pixel accept waits for the RMW
    wait_wr_ready();
    wr_req = 1'b1; wr_op = 2'd1; wr_x = 7'd20; wr_y = 6'd17; wr_page = 3'd0; wr_byte = 8'h00;
    tick();
    wr_req = 1'b0;
    model_apply(1, 20, 17, 0, 8'h00);
    chk("wr_ready_drop_on_accept", 32'(wr_ready), 0);
    do_read(2, 20, d, lat);
    chk("rmw_read_latency", lat, 5);
    chk("rmw_read_data", 32'(d), 32'h02);
    wait_wr_ready();

    // Clear to 0xFF while reads stream continuously
    start_clear(8'hFF);
    maxlat = 0;
    n = 0;
    while (clr_busy === 1'b1 && n < 1500) begin
      a   = $urandom_range(0, 1023);
      old = model[a];
      do_read(a / 128, a % 128, d, lat);
      if (lat > maxlat) maxlat = lat;
      checks++;
      assert (d === old || d === 8'hFF) else begin
        errors++;
        $error("FAIL clr_stream_data observed=%0h expected=%0h_or_ff", d, old);
      end
      n++;
    end
    chk("clr_stream_done", 32'(clr_busy), 0);
    chk("clr_stream_max_latency", maxlat, 3);
    model_fill(1024, 8'hFF);
    for (int i = 0; i < 1024; i++) begin
      do_read(i / 128, i % 128, d, lat);
      chk("fill_ff", 32'(d), 32'hFF);
    end

    // Same-cycle read + write + clear: read first, then write, clear ignored
    wait_wr_ready();
    d_read = 1'b1; d_page_idx = 3'd3; d_column_idx = 7'd9;
    wr_req = 1'b1; wr_op = 2'd3; wr_x = 7'd9; wr_page = 3'd3; wr_byte = 8'h3C;
    clr_req = 1'b1; clr_value = 8'h11;
    tick();
    d_read = 1'b0; wr_req = 1'b0; clr_req = 1'b0;
    chk("simul_clr_ignored", 32'(clr_busy), 0);
    lat = 0;
    while (d_data_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk("simul_read_latency", lat, 3);
    chk("simul_read_old", 32'(d_data), 32'hFF);
    model_apply(3, 9, 0, 3, 8'h3C);
    wait_wr_ready();
    chk("simul_clr_still_idle", 32'(clr_busy), 0);
    do_read(3, 9, d, lat);
    chk("simul_write_landed", 32'(d), 32'h3C);

    // Randomized drawing traffic checked against the model
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      x  = $urandom_range(0, 127);
      y  = $urandom_range(0, 63);
      pg = $urandom_range(0, 7);
      do_write(op, x, y, pg, 8'($urandom));
      a = (op == 3) ? pg * 128 + x : (y / 8) * 128 + x;
      do_read(a / 128, a % 128, d, lat);
      chk("rand_write_read", 32'(d), 32'(model[a]));
      a = $urandom_range(0, 1023);
      do_read(a / 128, a % 128, d, lat);
      chk("rand_read", 32'(d), 32'(model[a]));
    end

    // Reset in the middle of a clear, with counter at 300
    wait_wr_ready();
    start_clear(8'h55);
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_clr_busy", 32'(clr_busy), 0);
    chk("midclr_rst_wr_ready", 32'(wr_ready), 0);
    chk("midclr_rst_ready", 32'(d_data_ready), 0);
    chk("midclr_rst_d_data", 32'(d_data), 0);
    model_fill(300, 8'h55);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midclr_wr_ready_back", 32'(wr_ready), 1);
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 0 : 298 + i;
      do_read(a / 128, a % 128, d, lat);
      chk("midclr_contents", 32'(d), 32'(model[a]));
    end

    // Reset in the middle of an RMW: the byte is left untouched
    wait_wr_ready();
    wr_req = 1'b1; wr_op = 2'd2; wr_x = 7'd60; wr_y = 6'd35; wr_page = 3'd0;
    tick();
    wr_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrmw_rst_wr_ready", 32'(wr_ready), 0);
    chk("midrmw_rst_clr_busy", 32'(clr_busy), 0);
    chk("midrmw_rst_ready", 32'(d_data_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrmw_wr_ready_back", 32'(wr_ready), 1);
    do_read(4, 60, d, lat);
    chk("midrmw_byte_kept", 32'(d), 32'(model[4 * 128 + 60]));

    // A fresh clear after the resets runs to completion
    start_clear(8'h00);
    n = 0;
    while (clr_busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("reclear_cycles", n, 1024);
    model_fill(1024, 8'h00);
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 1023);
      do_read(a / 128, a % 128, d, lat);
      chk("reclear_contents", 32'(d), 32'(model[a]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_framebuffer.md
Name: display_framebuffer

Overview:
- Owns the 128x64 monochrome framebuffer: 8 pages x 128 columns x 8-bit bytes, one byte = 8 vertical pixels.
- Serves the display refresh engine's byte fetch port (d_read / d_page_idx / d_column_idx -> d_data / d_data_ready).
- Arbitrates one single-port RAM between three users: refresh reads, pixel/byte writes from drawing logic, and a full-screen clear sequencer.
- Refresh reads always have priority, so the SPI stream never starves behind drawing traffic.

Parameters:
- COLUMNS, 128, columns per page.
- PAGES, 8, pages (8 pixel rows each).
- ADDR_W, 10, RAM address width; address = page*COLUMNS + column.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- d_read  in  1  fetch request from display; may stay high several cycles
- d_page_idx  in  3  page of requested byte
- d_column_idx  in  7  column of requested byte
- d_data  out  8  fetched byte, held until next fetch
- d_data_ready  out  1  d_data valid for latest request
- wr_req  in  1  drawing request
- wr_op  in  2  0=clear pixel, 1=set pixel, 2=toggle pixel, 3=write byte
- wr_x  in  7  column 0..127
- wr_y  in  6  pixel row 0..63 (page = wr_y[5:3], bit = wr_y[2:0]); ops 0-2 only
- wr_page  in  3  page for op 3
- wr_byte  in  8  data for op 3
- wr_ready  out  1  write port can accept; transfer on wr_req && wr_ready
- clr_req  in  1  start full-screen fill
- clr_value  in  8  fill byte, latched at accept
- clr_busy  out  1  fill in progress

Behaviour:
- Reset values: d_data=0, d_data_ready=0, wr_ready=0, clr_busy=0, FSM=IDLE, all pending flags cleared. RAM contents are not reset. wr_ready rises on the first clock edge after rst_n deasserts.
- Reset asserted mid-operation aborts at once: pending read dropped, RMW abandoned (the RAM byte keeps whatever was last written), clear stops.
- Reader side:
  - Any edge sampling d_read=1 latches the address, sets rd_pend and clears d_data_ready.
  - If d_read stays high for several cycles, each sampled cycle re-latches; the latest address wins.
  - The RAM read is issued on the first cycle the FSM is free (IDLE or a CLEAR slot). RAM is synchronous, 1-cycle latency.
  - Data is registered into d_data and d_data_ready set 2 edges after the read issues.
  - Best case: d_data_ready high 3 edges after d_read is sampled.
  - Worst case (RMW in flight): +2 edges.
- FSM states: IDLE, RD_ISSUE, RD_CAPTURE, RMW_READ, RMW_MOD, WR_BYTE, CLEAR.
- IDLE priority order:
  - rd_pend -> RD_ISSUE.
  - else clear active -> CLEAR.
  - else accepted write -> RMW_READ (ops 0-2) or WR_BYTE (op 3).
- RD_ISSUE -> RD_CAPTURE -> back to CLEAR if clear is active, else IDLE.
- Write handshake:
  - wr_ready=1 only in IDLE with no rd_pend, no clear, no latched write.
  - On accept, op/x/y/page/byte are latched and wr_ready drops on the same edge.
  - wr_ready returns the edge after the RAM write completes.
- RMW:
  - RMW_READ issues the read of {wr_y[5:3], wr_x}.
  - RMW_MOD computes the new byte with mask 1<<wr_y[2:0]: op0 AND ~mask, op1 OR mask, op2 XOR mask. It writes the result that cycle.
  - RMW is atomic: a d_read arriving mid-RMW stays pending and is served right after.
- WR_BYTE: one write cycle to {wr_page, wr_x}.
- Clear:
  - clr_req is accepted only when clr_busy=0 and no write is latched; otherwise it is ignored (not queued).
  - On accept, clr_busy rises on the next edge.
  - CLEAR writes clr_value to address 0..1023, one per cycle.
  - A sampled rd_pend preempts for 2 cycles, then clear resumes at the same counter value.
  - After address 1023 is written, clr_busy falls on the next edge and the counter wraps to 0.
  - A refresh read of an address not yet cleared returns old data. That is acceptable.
- Simultaneous events:
  - d_read + wr_req in the same cycle: both latch; the read is served first.
  - clr_req + wr_req when both are acceptable: the write is accepted and clr_req is ignored.
- Address arithmetic: {page[2:0], column[6:0]}; no overflow is possible at the default parameters.

Decomposition:
- Shared package/header (alongside display_commands.v defines):
  - WR_OP_* encodings.
  - FB_COLUMNS / FB_PAGES / FB_ADDR_W constants.
- One sub-module: fb_ram_sp (single-port 1024x8 RAM, synchronous read, write-enable, inferred BRAM, no reset).

Test Plan:
- Reset, then clr_req with clr_value=0x00: clr_busy high exactly 1024 cycles with no readers; every d_read afterwards returns 0x00.
- Set pixel x=5,y=10, then d_read page 1 col 5 -> d_data=0x04. Toggle same pixel -> 0x00. Byte write page 7 col 127 = 0xA5 -> read returns 0xA5.
- d_read issued the cycle after a set-pixel accept -> RMW completes first; d_data_ready rises 5 edges after d_read; data shows the updated byte.
- Clear with 0xFF while the display module streams full refreshes: clear finishes, all 1024 bytes read 0xFF, and no d_read is ever delayed more than 3 edges.
- Same-cycle d_read + wr_req + clr_req from IDLE: read served, then write; clr_req ignored and clr_busy stays 0.
- rst_n pulsed low mid-clear (at counter 300) and mid-RMW: outputs immediately return to reset values; wr_ready back to 1 one edge after release; new clear completes normally.
